// File: rtl/wb_regfile_stage_pkg.sv
// Shared widths, encodings and constants for the writeback / register-file stage.
package wb_regfile_stage_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int RET_W      = 64;

  typedef enum logic [1:0] {
    RESULT_ALU     = 2'b00,
    RESULT_LOAD    = 2'b01,
    RESULT_PC4     = 2'b10,
    RESULT_ALU_ALT = 2'b11
  } resultSrcT;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } loadFunct3T;

  // The canonical pipeline bubble (add x0,x0,x0) does not count as retired.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0033;

endpackage

// File: rtl/wb_regfile_stage_regfile_2r1w.sv
// 31-entry register file with x0 hardwired to zero and write-first read ports.
module regfile_2r1w
  import wb_regfile_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]       rdata1,
  output logic [XLEN-1:0]       rdata2
);

  logic [XLEN-1:0] regs [1:31];
  logic            writeValid;

  assign writeValid = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (n_rst) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (writeValid) begin
      regs[waddr] <= wdata;
    end
  end

  // A same-cycle write to the address being read wins over the stored value.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = (writeValid && waddr == raddr1) ? wdata : regs[raddr1];
    if (raddr2 != '0) rdata2 = (writeValid && waddr == raddr2) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: result mux, load alignment, register file and retired-instruction counter.
module wb_regfile_stage
  import wb_regfile_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  RegWriteW,
  input  logic [1:0]            ResultSrcW,
  input  logic [XLEN-1:0]       ALUResultW,
  input  logic [XLEN-1:0]       ReadDataW,
  input  logic [XLEN-1:0]       PC_plus4W,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [XLEN-1:0]       InstrW,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  output logic [XLEN-1:0]       RD1D,
  output logic [XLEN-1:0]       RD2D,
  output logic [XLEN-1:0]       ResultW,
  output logic [RET_W-1:0]      InstretW
);

  logic [7:0]      loadByte;
  logic [15:0]     loadHalf;
  logic [XLEN-1:0] loadData;
  logic [RET_W-1:0] instretCount;

  // Halfword selection looks only at offset bit 1; misaligned halves are not trapped.
  always_comb begin
    loadByte = 8'(ReadDataW >> {ALUResultW[1:0], 3'b000});
    loadHalf = ALUResultW[1] ? ReadDataW[31:16] : ReadDataW[15:0];
    case (InstrW[14:12])
      F3_LB:   loadData = {{24{loadByte[7]}}, loadByte};
      F3_LBU:  loadData = {24'h0, loadByte};
      F3_LH:   loadData = {{16{loadHalf[15]}}, loadHalf};
      F3_LHU:  loadData = {16'h0, loadHalf};
      default: loadData = ReadDataW;
    endcase
  end

  always_comb begin
    case (resultSrcT'(ResultSrcW))
      RESULT_LOAD: ResultW = loadData;
      RESULT_PC4:  ResultW = PC_plus4W;
      default:     ResultW = ALUResultW;
    endcase
  end

  regfile_2r1w regFile (
    .clk    (clk),
    .n_rst  (n_rst),
    .we     (RegWriteW),
    .waddr  (RdW),
    .wdata  (ResultW),
    .raddr1 (Rs1D),
    .raddr2 (Rs2D),
    .rdata1 (RD1D),
    .rdata2 (RD2D)
  );

  always_ff @(posedge clk) begin
    if (n_rst) begin
      instretCount <= '0;
    end else if (InstrW != NOP_INSTR) begin
      instretCount <= instretCount + 1'b1;
    end
  end

  assign InstretW = instretCount;

endmodule

// File: doc/wb_regfile_stage.md
WB_REGFILE_STAGE -- requirements
Module: wb_regfile_stage

Interface
REQ-001 The module SHALL have one clock and one reset.
- Reset is synchronous and active-high.
- Ports are named clk and n_rst, per codebase naming.
- n_rst is active-high despite its name.
REQ-002 Port clk, input, 1 bit: rising-edge clock.
REQ-003 Port n_rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port RegWriteW, input, 1 bit: writeback enable from the MEM/WB register.
REQ-005 Port ResultSrcW, input, 2 bits: result select.
REQ-006 Port ALUResultW, input, 32 bits: ALU result, or load byte address.
REQ-007 Port ReadDataW, input, 32 bits: raw aligned word from data memory.
REQ-008 Port PC_plus4W, input, 32 bits: link value.
REQ-009 Port RdW, input, 5 bits: destination register.
REQ-010 Port InstrW, input, 32 bits: retiring instruction.
REQ-011 Ports Rs1D and Rs2D, input, 5 bits each: decode-stage read addresses.
REQ-012 Ports RD1D and RD2D, output, 32 bits each: decode-stage read data.
REQ-013 Port ResultW, output, 32 bits: final writeback value, also used for forwarding.
REQ-014 Port InstretW, output, 64 bits: retired-instruction count.

Function
REQ-015 ResultW SHALL be selected by ResultSrcW, combinationally:
- 00: ALUResultW.
- 01: load-aligned data.
- 10: PC_plus4W.
- 11: ALUResultW.
REQ-016 Load alignment SHALL use InstrW[14:12] and byte offset ALUResultW[1:0]:
- LB (000): sign-extend the selected byte.
- LBU (100): zero-extend the selected byte.
- LH (001): sign-extend the halfword at offset bit 1.
- LHU (101): zero-extend the halfword at offset bit 1.
- LW (010): pass the whole word.
- Any other funct3: pass the whole word.
REQ-017 Halfword loads SHALL ignore ALUResultW[0]; no misalignment trap.
REQ-018 The register file SHALL hold 31 writable 32-bit registers (x1..x31).
REQ-019 x0 SHALL always read 0, and writes to x0 SHALL be discarded.
REQ-020 Register writes SHALL occur on the rising clk edge when RegWriteW=1 and RdW!=0, storing ResultW.
REQ-021 Reads SHALL be combinational and write-first: if RegWriteW=1, RdW!=0 and RdW equals the read address, the read port SHALL return ResultW in the same cycle.
REQ-022 With Rs1D=Rs2D=RdW, both read ports SHALL bypass identically.
REQ-023 InstretW SHALL increment by 1 each cycle that InstrW is not the bubble value 0x0000_0033.
REQ-024 The bubble check SHALL use exact 32-bit equality only.
REQ-025 InstretW SHALL wrap from 0xFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-026 Output latency SHALL be:
- ResultW, RD1D, RD2D: 0 cycles (combinational).
- Register contents: visible as stored state from the next cycle.
- InstretW: updated 1 cycle after the retiring instruction.

Reset
REQ-027 While n_rst=1 at a rising edge, all of x1..x31 and InstretW SHALL clear to 0.
REQ-028 Reset SHALL take priority over a simultaneous write or count.
REQ-029 Reset mid-operation SHALL discard any in-flight write.
REQ-030 Combinational outputs SHALL follow their inputs during reset.
REQ-031 In the cycle after reset deasserts, RD1D and RD2D SHALL read 0 for every address, unless bypassed.

Structure
REQ-032 A shared package SHALL hold:
- The ResultSrc encodings.
- The load funct3 codes.
- The NOP constant 32'h0000_0033.
- The XLEN and register-address widths.
REQ-033 The register array SHALL be one sub-module, regfile_2r1w, with two write-first read ports and one write port.
REQ-034 Mux, load alignment and the retire counter SHALL live in the top module.

Verification
REQ-035 Load alignment:
- Stimulus: ReadDataW=0x8899_AABB, ALUResultW=0x...02, ResultSrcW=01, LB.
- Response: ResultW=0xFFFF_FF99.
- Same with LBU: ResultW=0x0000_0099.
- Same with LHU: ResultW=0x0000_8899.
REQ-036 Write and bypass:
- Stimulus: RegWriteW=1, RdW=5, ALUResultW=0x1234_5678, ResultSrcW=00, Rs1D=Rs2D=5.
- Response: RD1D=RD2D=0x1234_5678 in the same cycle.
- Next cycle with RegWriteW=0: both still read 0x1234_5678.
REQ-037 x0 protection:
- Stimulus: RegWriteW=1, RdW=0, ResultW=0xDEAD_BEEF.
- Response: Rs1D=0 reads 0, both in the same cycle and the next.
REQ-038 JAL link:
- Stimulus: ResultSrcW=10, PC_plus4W=0x0000_0104, RdW=1, RegWriteW=1.
- Response: x1 reads 0x0000_0104 afterwards.
REQ-039 Retire counter:
- Stimulus: 3 cycles of InstrW=0x0000_0033, then 4 cycles of 0x0050_0093.
- Response: InstretW=4.
- Preload the counter to all-ones by force, then one retire: InstretW=0.
REQ-040 Reset priority:
- Stimulus: n_rst=1 in the same cycle as a write of 0xA5A5_A5A5 to x7.
- Response: x7 reads 0 and InstretW=0 the next cycle.
